// File: rtl/synth_pkg.sv
// Shared oscillator/voice definitions: waveform select codes and default sample width.
package synth_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE = 2'b00,
    WAVE_SQR  = 2'b01,
    WAVE_SAW  = 2'b10,
    WAVE_TRI  = 2'b11
  } wave_sel_t;

  localparam int SAMPLE_W = 24;

endpackage

// File: rtl/mux4to1.sv
// Registered 4:1 waveform selector at the oscillator output (sine/square/saw/triangle).
// One clk from sampled sel/data to out; en=0 holds out; no handshake or backpressure.
module mux4to1
  import synth_pkg::*;
#(
  parameter int ow = SAMPLE_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [1:0]    sel,
  input  logic [ow-1:0] sin_out,
  input  logic [ow-1:0] sqr_out,
  input  logic [ow-1:0] saw_out,
  input  logic [ow-1:0] tri_out,
  output logic [ow-1:0] out
);

  logic [ow-1:0] sel_dat;

  // Fully decoded: an unknown select yields unknown data rather than a silent fallback.
  always_comb begin
    sel_dat = {ow{1'bx}};
    case (wave_sel_t'(sel))
      WAVE_SINE: sel_dat = sin_out;
      WAVE_SQR:  sel_dat = sqr_out;
      WAVE_SAW:  sel_dat = saw_out;
      WAVE_TRI:  sel_dat = tri_out;
      default:   sel_dat = {ow{1'bx}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else if (en) begin
      out <= sel_dat;
    end
  end

`ifndef SYNTHESIS
  // Suppresses the checks until a reset has been seen, so $past never looks at pre-reset junk.
  logic past_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      past_vld <= 1'b1;
    end
  end

  a_load: assert property (@(posedge clk)
    past_vld && $past(en && !reset) |-> out == $past(sel_dat));

  a_hold: assert property (@(posedge clk)
    past_vld && $past(!en && !reset) |-> $stable(out));

  a_reset: assert property (@(posedge clk)
    past_vld && $past(reset) |-> out == '0);
`endif

endmodule

// File: tb/tb_mux4to1.sv
// Directed bench for mux4to1: stimulus pushes expected samples, a monitor pops and compares.
module tb_mux4to1;

  localparam int W = 24;

  typedef struct {
    logic [W-1:0] exp;
    string        name;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         en;
  logic [1:0]   sel;
  logic [W-1:0] sin_out;
  logic [W-1:0] sqr_out;
  logic [W-1:0] saw_out;
  logic [W-1:0] tri_out;
  logic [W-1:0] out;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mux4to1 #(.ow(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .sel     (sel),
    .sin_out (sin_out),
    .sqr_out (sqr_out),
    .saw_out (saw_out),
    .tri_out (tri_out),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge, then queue the value out must hold after the rising edge.
  task automatic step(input logic r, input logic e, input logic [1:0] s,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic [W-1:0] d,
                      input logic [W-1:0] x, input string nm);
    exp_t item;
    @(negedge clk);
    reset   = r;
    en      = e;
    sel     = s;
    sin_out = a;
    sqr_out = b;
    saw_out = c;
    tri_out = d;
    @(posedge clk);
    item.exp  = x;
    item.name = nm;
    exp_q.push_back(item);
  endtask

  // Monitor: out is a registered sample every cycle, checked 1 time unit after the edge.
  initial begin
    exp_t item;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        item = exp_q.pop_front();
        checks++;
        if (out !== item.exp) begin
          errors++;
          $display("FAIL %s: out=%h expected=%h", item.name, out, item.exp);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] s1, s2, s3, s4;
    logic [W-1:0] trk [4];
    s1 = 24'h111111;
    s2 = 24'h222222;
    s3 = 24'h333333;
    s4 = 24'h444444;
    trk[0] = 24'h000000;
    trk[1] = 24'h7FFFFF;
    trk[2] = 24'h800000;
    trk[3] = 24'hFFFFFF;

    reset = 1'b1; en = 1'b0; sel = 2'b00;
    sin_out = '0; sqr_out = '0; saw_out = '0; tri_out = '0;

    // Reset with every input high and en=1 must still clear out.
    step(1'b1, 1'b1, 2'b11, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, "reset");
    step(1'b1, 1'b1, 2'b00, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, "reset_hold");

    // Select sweep.
    step(1'b0, 1'b1, 2'b00, s1, s2, s3, s4, 24'h111111, "sel_sine");
    step(1'b0, 1'b1, 2'b01, s1, s2, s3, s4, 24'h222222, "sel_square");
    step(1'b0, 1'b1, 2'b10, s1, s2, s3, s4, 24'h333333, "sel_saw");
    step(1'b0, 1'b1, 2'b11, s1, s2, s3, s4, 24'h444444, "sel_tri");

    // Hold while disabled, even as sel and saw data change.
    step(1'b0, 1'b1, 2'b10, s1, s2, s3, s4, 24'h333333, "hold_load");
    step(1'b0, 1'b0, 2'b00, s1, s2, 24'h555555, s4, 24'h333333, "hold_0");
    step(1'b0, 1'b0, 2'b00, s1, s2, 24'h555555, s4, 24'h333333, "hold_1");
    step(1'b0, 1'b0, 2'b11, s1, s2, 24'h555555, s4, 24'h333333, "hold_2");
    step(1'b0, 1'b1, 2'b00, s1, s2, 24'h555555, s4, 24'h111111, "hold_release");
    step(1'b0, 1'b1, 2'b10, s1, s2, 24'h555555, s4, 24'h555555, "saw_new_data");

    // Reset priority over en/sel, then recovery on the first enabled edge.
    step(1'b0, 1'b1, 2'b11, s1, s2, s3, s4, 24'h444444, "pri_load");
    step(1'b1, 1'b1, 2'b11, s1, s2, s3, s4, 24'h000000, "pri_reset");
    step(1'b0, 1'b1, 2'b11, s1, s2, s3, s4, 24'h444444, "pri_recover");
    step(1'b1, 1'b0, 2'b01, s1, s2, s3, s4, 24'h000000, "reset_en0");
    step(1'b0, 1'b0, 2'b01, s1, s2, s3, s4, 24'h000000, "hold_after_reset");

    // Bit-exact data tracking on the sine input.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 2'b00, trk[i], s2, s3, s4, trk[i], $sformatf("track_%0d", i));
    end

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
